// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns a 1-cycle-latency FIFO read port into a valid/ready stream.
// Defining FIFO_RD_STREAM_CNT_EN adds the 16-bit rd_count transfer counter port.
module fifo_rd_stream #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              err_underflow
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [15:0]       rd_count
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state_q, state_d;
    logic [1:0] occ_q, occ_d, rem;
    logic inf_q, err_q, xfer;
    logic [DATA_W-1:0] b0_q, b0_d, b1_q, b1_d;
    logic [2:0] credit;
    assign m_valid = occ_q != 2'd0;
    assign m_data = b0_q;
    assign xfer = m_valid & m_ready;
    assign busy = state_q != IDLE;
    assign err_underflow = err_q;
    assign rem = occ_q - {1'b0, xfer};
    // a word leaving this cycle frees its slot, keeping one word per cycle under m_ready
    assign credit = {1'b0, rem} + {2'b0, inf_q};
    assign fifo_rd = (state_q == RUN) & rd_en & ~fifo_empty & (credit < 3'd2);
    always_comb begin
        state_d = state_q;
        occ_d = rem + {1'b0, inf_q};
        b0_d = xfer ? b1_q : b0_q;
        b1_d = b1_q;
        if (inf_q && rem == 2'd0) b0_d = fifo_data;
        else if (inf_q) b1_d = fifo_data;
        case (state_q)
            IDLE:    state_d = rd_en ? RUN : IDLE;
            RUN:     state_d = rd_en ? RUN : DRAIN;
            DRAIN:   state_d = rd_en ? RUN : (!inf_q && occ_q == 2'd0) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            occ_q <= 2'd0;
            inf_q <= 1'b0;
            b0_q <= '0;
            b1_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q <= occ_d;
            inf_q <= fifo_rd;
            b0_q <= b0_d;
            b1_q <= b1_d;
            err_q <= err_q | (fifo_rd & fifo_empty);
        end
    end
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [15:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 16'd0;
        else cnt_q <= cnt_q + {15'd0, xfer};
    end
    assign rd_count = cnt_q;
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: queue-based FIFO/stream reference model with per-cycle compare.
module tb_fifo_rd_stream;
    logic clk = 1'b0, rst_n = 1'b0, rd_en = 1'b0, fifo_empty = 1'b1, m_ready = 1'b0;
    logic [7:0] fifo_data = 8'd0;
    logic fifo_rd, m_valid, busy, err_underflow;
    logic [7:0] m_data;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [15:0] rd_count;
`endif
    always #5 clk = ~clk;

    fifo_rd_stream #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd(fifo_rd), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .busy(busy), .err_underflow(err_underflow)
`ifdef FIFO_RD_STREAM_CNT_EN
        , .rd_count(rd_count)
`endif
    );

    int total = 0, bad = 0;
    int mstate, ntx, rd_pulses, cyc, first_valid, first_x, last_x;
    logic [7:0] fq[$], outq[$], got[$];
    logic [7:0] infw;
    bit inf_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic preload(input int n);
        for (int i = 1; i <= n; i++) fq.push_back(8'(i));
    endtask

    task automatic model_clear();
        fq.delete(); outq.delete(); got.delete();
        inf_m = 0; mstate = 0; ntx = 0; rd_pulses = 0; cyc = 0;
        first_valid = -1; first_x = -1; last_x = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; rd_en = 1'b0; m_ready = 1'b0; fifo_data = 8'd0; fifo_empty = 1'b1;
        #1;
        chk("rst_fifo_rd", fifo_rd, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_underflow, 0);
`ifdef FIFO_RD_STREAM_CNT_EN
        chk("rst_rd_count", rd_count, 0);
`endif
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // one clock cycle: drive, compare against the model, advance the model
    task automatic step(input bit re, input bit mr);
        bit xe, re_e;
        int nst;
        @(negedge clk);
        rd_en = re; m_ready = mr; fifo_empty = fq.size() == 0;
        #1;
        xe = outq.size() != 0 && mr;
        re_e = mstate == 1 && re && fq.size() != 0 && (outq.size() + int'(inf_m) - int'(xe) < 2);
        chk("fifo_rd", fifo_rd, re_e);
        chk("m_valid", m_valid, outq.size() != 0);
        if (outq.size() != 0) chk("m_data", m_data, outq[0]);
        chk("busy", busy, mstate != 0);
        chk("err_underflow", err_underflow, 0);
`ifdef FIFO_RD_STREAM_CNT_EN
        chk("rd_count", rd_count, ntx & 32'hffff);
`endif
        if (outq.size() != 0 && first_valid < 0) first_valid = cyc;
        nst = mstate;
        if (mstate == 0 && re) nst = 1;
        if (mstate == 1 && !re) nst = 2;
        if (mstate == 2) nst = re ? 1 : (!inf_m && outq.size() == 0) ? 0 : 2;
        mstate = nst;
        if (xe) begin
            got.push_back(outq.pop_front());
            ntx++;
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
        end
        if (inf_m) outq.push_back(infw);
        inf_m = re_e;
        if (re_e) begin
            infw = fq.pop_front();
            rd_pulses++;
        end
        @(posedge clk);
        #1;
        if (re_e) fifo_data = infw;
        cyc++;
    endtask

    initial begin
        bit re, mr;
        logic [7:0] nw;
        model_clear();
        do_reset();

        preload(16);
        for (int i = 0; i < 22; i++) step(1, 1);
        chk("drain_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) chk("drain_order", got[i], i + 1);
        chk("drain_first_valid", first_valid, 3);
        chk("drain_consecutive", last_x - first_x, 15);
        chk("drain_rd_pulses", rd_pulses, 16);

        do_reset();
        preload(8);
        for (int i = 0; i < 3; i++) step(1, 1);
        for (int i = 0; i < 5; i++) step(1, 0);
        chk("bp_hold_data", m_data, 1);
        chk("bp_hold_valid", m_valid, 1);
        chk("bp_no_rd", fifo_rd, 0);
        chk("bp_occ", outq.size(), 2);
        for (int i = 0; i < 15; i++) step(1, 1);
        chk("bp_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("bp_order", got[i], i + 1);

        do_reset();
        preload(8);
        step(1, 1);
        step(1, 1);
        step(0, 1);
        chk("stop_drain_busy", busy, 1);
        for (int i = 0; i < 3; i++) step(0, 1);
        chk("stop_count", got.size(), 1);
        if (got.size() > 0) chk("stop_word", got[0], 1);
        chk("stop_rd_pulses", rd_pulses, 1);
        chk("stop_idle", busy, 0);

        do_reset();
        preload(3);
        for (int i = 0; i < 12; i++) step(1, 1);
        chk("empty_rd_pulses", rd_pulses, 3);
        chk("empty_count", got.size(), 3);
        chk("empty_no_valid", m_valid, 0);
        chk("empty_busy", busy, 1);

        do_reset();
        preload(8);
        for (int i = 0; i < 8; i++) step(1, 0);
        chk("rst_pre_occ", m_valid, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_m_valid", m_valid, 0);
        chk("async_busy", busy, 0);
`ifdef FIFO_RD_STREAM_CNT_EN
        chk("async_rd_count", rd_count, 0);
`endif
        do_reset();
        preload(4);
        step(1, 1);
        chk("post_rst_first_fetch", rd_pulses, 0);
        for (int i = 0; i < 10; i++) step(1, 1);
        chk("post_rst_count", got.size(), 4);

`ifdef FIFO_RD_STREAM_CNT_EN
        do_reset();
        preload(17);
        for (int i = 0; i < 25; i++) step(1, 1);
        chk("cnt_17", rd_count, 17);
`endif

        do_reset();
        re = 1; nw = 8'h40;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0 && fq.size() < 20) begin
                fq.push_back(nw);
                nw++;
            end
            if ($urandom_range(9) == 0) re = !re;
            mr = (i % 600 < 300) ? ($urandom_range(3) != 0) : ($urandom_range(1) == 1);
            step(re, mr);
        end
        chk("rand_activity", ntx > 100, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
